// File: rtl/lfsr_decrypt.sv
// LFSR stream decryptor: reads taps and seed from memory, decrypts MSG_LEN bytes, strips the space preamble, pads with spaces.
// One byte per cycle in DEC; done rises MSG_LEN+2+s edges after start is accepted. No backpressure, start ignored while busy.
module lfsr_decrypt #(
  parameter int AW       = 8,
  parameter int TAP_ADDR = 1,
  parameter int CT_BASE  = 128,
  parameter int OUT_BASE = 0,
  parameter int MSG_LEN  = 64,
  parameter int PRE_MAX  = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] raddr,
  input  logic [7:0]    data_in,
  output logic          write_en,
  output logic [AW-1:0] waddr,
  output logic [7:0]    data_out
);

  localparam int IW = $clog2(MSG_LEN);
  localparam int SW = $clog2(PRE_MAX + 1);

  typedef enum logic [2:0] {IDLE, RD_TAPS, SEED, DEC, PAD, DONE} state_t;

  state_t        state, state_nxt;
  logic [4:0]    taps, lfsr, lfsr_nxt;
  logic [IW-1:0] i, wp;
  logic [SW-1:0] s;
  logic          strip;
  logic [7:0]    plain;
  logic          strip_hit;
  logic          i_last, wp_last;

  assign lfsr_nxt  = {lfsr[3:0], ^(lfsr & taps)};
  assign plain     = data_in ^ {3'b000, lfsr};
  assign strip_hit = strip && (plain == 8'h20) && (s < SW'(PRE_MAX));
  assign i_last    = (i == IW'(MSG_LEN - 1));
  assign wp_last   = (wp == IW'(MSG_LEN - 1));

  always_comb begin
    state_nxt = state;
    raddr     = '0;
    write_en  = 1'b0;
    waddr     = '0;
    data_out  = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RD_TAPS;
      end
      RD_TAPS: begin
        raddr     = AW'(TAP_ADDR);
        state_nxt = SEED;
      end
      SEED: begin
        raddr     = AW'(CT_BASE);
        state_nxt = DEC;
      end
      DEC: begin
        raddr = AW'(CT_BASE) + AW'(i);
        if (!strip_hit) begin
          write_en = 1'b1;
          waddr    = AW'(OUT_BASE) + AW'(wp);
          data_out = plain;
        end
        // The last byte can never be stripped (s stays far below MSG_LEN), so registered s is final here.
        if (i_last) state_nxt = (s != '0) ? PAD : DONE;
      end
      PAD: begin
        write_en = 1'b1;
        waddr    = AW'(OUT_BASE) + AW'(wp);
        data_out = 8'h20;
        if (wp_last) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
      taps  <= '0;
      lfsr  <= '0;
      i     <= '0;
      wp    <= '0;
      s     <= '0;
      strip <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) done <= 1'b0;
        end
        RD_TAPS: taps <= data_in[4:0];
        SEED: begin
          // Preamble byte is 0x20, whose low five bits are zero, so the ciphertext low bits are the seed.
          lfsr  <= data_in[4:0];
          i     <= '0;
          wp    <= '0;
          s     <= '0;
          strip <= 1'b1;
        end
        DEC: begin
          lfsr <= lfsr_nxt;
          i    <= i + IW'(1);
          if (strip_hit) begin
            s <= s + SW'(1);
          end else begin
            wp    <= wp + IW'(1);
            strip <= 1'b0;
          end
        end
        PAD: wp <= wp + IW'(1);
        default: ;
      endcase
      if (state_nxt == DONE) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lfsr_decrypt.sv
// Directed bench for lfsr_decrypt: behavioural 256-byte memory, bench-side encryptor, fixed expected plaintext layouts.
module tb_lfsr_decrypt;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] raddr;
  logic [7:0] data_in;
  logic       write_en;
  logic [7:0] waddr;
  logic [7:0] data_out;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int order_err = 0;
  int done_cnt = 0;
  logic done_q = 1'b0;

  logic [7:0] mem [256];

  lfsr_decrypt dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .done     (done),
    .raddr    (raddr),
    .data_in  (data_in),
    .write_en (write_en),
    .waddr    (waddr),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  assign data_in = mem[raddr];

  always @(posedge clk) begin
    if (write_en) begin
      if (waddr != 8'(wr_cnt)) order_err = order_err + 1;
      mem[waddr] = data_out;
      wr_cnt = wr_cnt + 1;
    end
    if (done && !done_q) done_cnt = done_cnt + 1;
    done_q = done;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ciphertext = plaintext ^ keystream; plaintext is pre spaces, the message, then spaces to 64 bytes.
  task automatic load(input int pre, input logic [4:0] tp, input logic [4:0] sd);
    string      m;
    logic [7:0] pt;
    logic [4:0] l;
    m = "HELLO WORLD";
    for (int k = 0; k < 256; k++) mem[k] = 8'hEE;
    mem[1] = {3'b101, tp};
    l = sd;
    for (int k = 0; k < 64; k++) begin
      if (k < pre) pt = 8'h20;
      else if (k < pre + 11) pt = m[k - pre];
      else pt = 8'h20;
      mem[128 + k] = pt ^ {3'b000, l};
      l = {l[3:0], ^(l & tp)};
    end
  endtask

  task automatic chk_out(input int lead);
    string      m;
    logic [7:0] e;
    m = "HELLO WORLD";
    for (int k = 0; k < 64; k++) begin
      if (k < lead) e = 8'h20;
      else if (k < lead + 11) e = m[k - lead];
      else e = 8'h20;
      chk($sformatf("out[%0d]", k), {24'd0, mem[k]}, {24'd0, e});
    end
  endtask

  // Edge 0 accepts start; rise is the edge on which done was first seen high (-1 if never).
  task automatic go(input int repulse_at, input int reset_at, output int rise);
    bit stop;
    @(negedge clk);
    wr_cnt    = 0;
    order_err = 0;
    done_cnt  = 0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_clr", {31'd0, done}, 32'd0);
    rise = -1;
    stop = 1'b0;
    for (int e = 1; e <= 200 && !stop; e++) begin
      if (e == repulse_at) start = 1'b1;
      if (e == reset_at) reset = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (reset) begin
        chk("rst_we", {31'd0, write_en}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_raddr", {24'd0, raddr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_we", {31'd0, write_en}, 32'd0);
        stop = 1'b1;
      end else if (done) begin
        rise = e;
        stop = 1'b1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic full_run(input string nm, input int pre, input logic [4:0] tp, input logic [4:0] sd,
                          input int lead, input int exp_edge, input int repulse_at);
    int rise;
    load(pre, tp, sd);
    go(repulse_at, 0, rise);
    chk({nm, "_done_edge"}, rise, exp_edge);
    chk({nm, "_done_hold"}, {31'd0, done}, 32'd1);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_writes"}, wr_cnt, 64);
    chk({nm, "_order"}, order_err, 0);
    chk_out(lead);
  endtask

  initial begin
    int rise;
    reset = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_we", {31'd0, write_en}, 32'd0);
      chk("rst_raddr", {24'd0, raddr}, 32'd0);
      chk("rst_waddr", {24'd0, waddr}, 32'd0);
      chk("rst_dout", {24'd0, data_out}, 32'd0);
    end
    reset = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("idle_raddr", {24'd0, raddr}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);
    end

    full_run("pre7", 7, 5'h12, 5'h0A, 0, 73, 0);
    full_run("pre12", 12, 5'h1E, 5'h01, 0, 78, 0);
    full_run("pre15", 15, 5'h14, 5'h1F, 3, 78, 0);
    full_run("repulse", 7, 5'h12, 5'h0A, 0, 73, 13);

    load(7, 5'h12, 5'h0A);
    go(0, 23, rise);
    chk("aborted_rise", rise, -1);
    chk("aborted_pulses", done_cnt, 0);
    full_run("rerun", 7, 5'h12, 5'h0A, 0, 73, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_decrypt.md
Name: lfsr_decrypt

Overview:
- Decryption engine and memory client of the 8-bit x 256 data memory; the receive-side counterpart to the LFSR encryptor that fills [CT_BASE +: 64].
- Reads taps from mem[TAP_ADDR] and recovers the LFSR seed from the first ciphertext byte, because the preamble is always ASCII space (0x20).
- Decrypts 64 bytes, strips the leading preamble, and writes plaintext to [OUT_BASE +: 64], right-padded with 0x20.
- Drives the memory's combinational read port and clocked write port directly.

Parameters:
- AW, 8, memory address width (log2 of 256-byte memory)
- TAP_ADDR, 1, address of feedback taps (bits [4:0])
- CT_BASE, 128, first ciphertext byte
- OUT_BASE, 0, first plaintext output byte
- MSG_LEN, 64, bytes read and bytes written
- PRE_MAX, 12, maximum preamble bytes stripped

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; accepted only in IDLE
- done  out  1  registered; high when a run completes, cleared when the next start is accepted or on reset
- raddr  out  AW  memory read address
- data_in  in  8  memory read data (combinational, same cycle as raddr)
- write_en  out  1  memory write enable
- waddr  out  AW  memory write address
- data_out  out  8  memory write data

Behaviour:
- Reset: state=IDLE; done=0; write_en=0; raddr=waddr=0; data_out=0; taps, lfsr and all counters = 0. Reset wins over start in the same cycle.
- raddr, waddr, write_en and data_out are decoded combinationally from registered state. Outside DEC/PAD write_en=0, waddr=0 and data_out=0.
- LFSR step (5 bits): next = {lfsr[3:0], ^(lfsr & taps)}.
- Keystream: key = {3'b000, lfsr}; plain = data_in ^ key.
- IDLE: raddr=0. If start=1, clear done and go to RD_TAPS. Otherwise hold state and done.
- RD_TAPS (1 cycle): raddr=TAP_ADDR; taps <= data_in[4:0]; go to SEED.
- SEED (1 cycle): raddr=CT_BASE; lfsr <= data_in[4:0] (0x20 has low 5 bits = 0). Also i<=0, wp<=0, s<=0, strip<=1. Go to DEC.
- DEC (one byte per cycle, i=0..MSG_LEN-1): raddr=CT_BASE+i.
  - Strip case: strip=1 and plain==0x20 and s<PRE_MAX → no write; s<=s+1.
  - Write case: otherwise write_en=1, waddr=OUT_BASE+wp, data_out=plain; wp<=wp+1; strip<=0. Once strip=0 it stays 0 for the rest of the run.
  - Every DEC cycle: lfsr<=next, i<=i+1.
  - After i==MSG_LEN-1, go to PAD if s>0, else DONE.
- PAD: write_en=1, waddr=OUT_BASE+wp, data_out=0x20; wp<=wp+1. After wp==MSG_LEN-1, go to DONE.
- DONE (1 cycle): done<=1; go to IDLE.
- Boundaries and counts:
  - Exactly MSG_LEN writes per run, to addresses OUT_BASE..OUT_BASE+63, in ascending order.
  - s is never more than PRE_MAX. If there are more leading spaces, the extra ones are written out as plaintext.
  - A message whose first character is a space loses it when it falls inside the stripped region. This is a documented constraint on the encryptor side.
  - Address arithmetic is modulo 2^AW.
- Latency: count the edge that accepts start as edge 0. DEC covers edges 3..66; done rises on edge 66+s.
- start while not in IDLE: ignored; the run is unaffected.
- Reset mid-run: back to IDLE on that edge, done=0, no write in the following cycle. Partially written output is left in memory. A new start re-runs from scratch.
- taps==0: the LFSR holds its seed. This is legal; no special handling.

Test Plan:
- Reset with start=1 held → done=0, write_en=0, raddr=waddr=data_out=0 for every reset cycle; state stays IDLE after reset drops.
- Bench encrypts "HELLO WORLD" with taps=0x12, seed=0x0A, preamble 7, total 64 bytes → mem[0:10]="HELLO WORLD", mem[11:63]=0x20, s=7, done rises on edge 73, exactly 64 write pulses.
- Same setup with preamble 12 and taps=0x1E, seed=0x01 → plaintext at mem[0], done on edge 78, mem[52:63]=0x20.
- Preamble 15 spaces, taps=0x14, seed=0x1F → 12 stripped; mem[0:2]=0x20 followed by the message; done on edge 78.
- start re-pulsed at DEC i=10 → ignored; output matches the single-run result; done pulses once per run.
- reset asserted at DEC i=20, then a new start → write_en=0 the cycle after reset; second run output is fully correct; done=0 until the second run completes.
